// File: rtl/instr_pkg.sv
// Shared types, RV32I field constants and encode/range-check helpers for instr_encoder.
// Latency: pure combinational functions, no state.
// Backpressure: n/a (package only).
package instr_pkg;

    // Symbolic operations accepted by the encoder; 7 is reserved.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ADDI = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4,
        OP_BEQ  = 3'd5,
        OP_NOP  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 / funct7
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = {12'd0, 5'd0, F3_ADDI, 5'd0, OPC_OPIMM};

    // Loader FSM states, kept as plain constants for compatibility with older tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Build the 32-bit instruction word. Immediates are simply truncated to
    // their field; register fields that a format does not carry are dropped,
    // so they come out as zero. Anything unrecognised becomes a NOP.
    function automatic logic [31:0] encode(
        input op_e         op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        case (op)
            OP_ADD:  encode = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:  encode = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_ADDI: encode = {imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM};
            OP_LW:   encode = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
            OP_SW:   encode = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
            OP_BEQ:  encode = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                               imm[4:1], imm[11], OPC_BRANCH};
            default: encode = NOP_WORD;
        endcase
    endfunction

    // True when the operation cannot be represented exactly: immediate does
    // not fit its signed field, branch offset is odd, or the op is reserved.
    function automatic logic imm_bad(input op_e op, input logic [31:0] imm);
        logic fits12;
        logic fits13;
        fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
        fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
        case (op)
            OP_ADDI, OP_LW, OP_SW: imm_bad = !fits12;
            OP_BEQ:                imm_bad = !fits13 || imm[0];
            OP_RSVD:               imm_bad = 1'b1;
            default:               imm_bad = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Generic first-word-fall-through FIFO holding encoded instruction words.
// Latency: a word pushed at edge N is visible on rd_data (empty=0) in cycle N+1.
// Backpressure: push is ignored while full, pop is ignored while empty; caller gates with full/empty.
//
// Ports: clk, reset (sync, active-high), push/wr_data, pop/rd_data, full, empty, count.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rptr];

    // Storage needs no reset; occupancy is tracked by the counters below.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic RV32I ops into 32-bit words and streams them to instruction memory at consecutive addresses.
// Latency: op accepted at edge N -> mem_we with its word in cycle N+1; one word/cycle with mem_ready high.
// Backpressure: in_ready drops when the FIFO is full, the address space is used up, or a restart is draining; writes hold while !mem_ready.
//
// Ports: clk, reset (sync, active-high); in_valid/in_ready with in_op, in_rd, in_rs1, in_rs2, in_imm;
//        restart (one-cycle rewind to address 0); mem_we/mem_addr/mem_wdata/mem_ready write port;
//        prog_len (words written since reset/restart), busy, err (sticky encoding error).
// Build option: define ENC_RANGE_CHECK_EN to reject unrepresentable ops (flagged on err, not written);
//        otherwise immediates are truncated, op 7 becomes NOP and err is constant 0.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Instruction memory capacity in words.
    localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W:0]   issued;

    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       enc_word;
    logic [31:0]       fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    // issued counts words committed to the FIFO, so the program can never
    // overrun memory even while earlier words are still waiting to be written.
    assign in_ready = ((state == ST_IDLE) || (state == ST_LOAD))
                      && !fifo_full && (issued < CAP);
    assign accept   = in_valid && in_ready;
    assign enc_word = encode(op_e'(in_op), in_rd, in_rs1, in_rs2, in_imm);

`ifdef ENC_RANGE_CHECK_EN
    logic enc_bad;

    // A bad op still completes its handshake so the producer is never stuck;
    // it is only dropped on the way into the FIFO.
    assign enc_bad = imm_bad(op_e'(in_op), in_imm);
    assign push    = accept && !enc_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (restart && (state != ST_DRAIN)) begin
            err <= 1'b0;
        end else if (accept && enc_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Word buffer
    // ------------------------------------------------------------------
    word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (enc_word),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ------------------------------------------------------------------
    // Memory side
    // ------------------------------------------------------------------
    // The head word and prog_len only move on pop, so the write request
    // stays stable for as long as memory stalls.
    assign mem_we    = !fifo_empty && (state != ST_DONE);
    assign mem_addr  = prog_len[ADDR_W-1:0];
    assign mem_wdata = mem_we ? fifo_rd : 32'd0;
    assign pop       = mem_we && mem_ready;
    assign busy      = (fifo_count != '0) || (state == ST_DRAIN);

    // ------------------------------------------------------------------
    // Loader FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            issued   <= '0;
            prog_len <= '0;
        end else begin
            if (push) issued   <= issued + LEN_ONE;
            if (pop)  prog_len <= prog_len + LEN_ONE;

            case (state)
                ST_IDLE: begin
                    if (restart)     state <= ST_DRAIN;
                    else if (accept) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (restart)              state <= ST_DRAIN;
                    else if (prog_len == CAP) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (restart) state <= ST_DRAIN;
                end
                default: begin
                    // Draining: words already queued still go out at their
                    // addresses; rewind only once nothing is left to write.
                    // restart is ignored here.
                    if (fifo_empty) begin
                        state    <= ST_IDLE;
                        issued   <= '0;
                        prog_len <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure hold,
// address-space fill to DONE, restart rewind and mid-operation reset, with a
// randomized stream scored against a field-arithmetic reference model.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [ADDR_W:0]   prog_len;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    instr_encoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .restart   (restart),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .prog_len  (prog_len),
        .busy      (busy),
        .err       (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // Word built from the instruction-format field layout with plain arithmetic.
    function automatic logic [31:0] model_word(input longint op, input longint rd,
                                               input longint rs1, input longint rs2,
                                               input longint imm);
        longint w;
        case (op)
            0: w = rs2 * 2**20 + rs1 * 2**15 + rd * 128 + 51;
            1: w = 32 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + rd * 128 + 51;
            2: w = (imm & 4095) * 2**20 + rs1 * 2**15 + rd * 128 + 19;
            3: w = (imm & 4095) * 2**20 + rs1 * 2**15 + 2 * 4096 + rd * 128 + 3;
            4: w = ((imm >> 5) & 127) * 2**25 + rs2 * 2**20 + rs1 * 2**15
                   + 2 * 4096 + (imm & 31) * 128 + 35;
            5: w = ((imm >> 12) & 1) * 64'h8000_0000 + ((imm >> 5) & 63) * 2**25
                   + rs2 * 2**20 + rs1 * 2**15 + ((imm >> 1) & 15) * 256
                   + ((imm >> 11) & 1) * 128 + 99;
            default: w = 19;
        endcase
        return w[31:0];
    endfunction

    function automatic bit model_bad(input longint op, input longint imm);
        bit bad = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        if (op == 7) bad = 1'b1;
        else if (op == 2 || op == 3 || op == 4) bad = (imm < -2048) || (imm > 2047);
        else if (op == 5) bad = (imm < -4096) || (imm > 4095) || ((imm & 1) != 0);
`endif
        return bad;
    endfunction

    logic [31:0] q_data[$];
    int          q_addr[$];
    int          m_idx    = 0;   // words pushed since reset/restart
    int          m_issued = 0;
    bit          m_err    = 1'b0;

    // Scoreboard: score writes, then record any handshake into the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we && mem_ready) begin
                if (q_data.size() == 0) begin
                    chk("unexpected_write", {mem_addr, mem_wdata}, 0);
                end else begin
                    chk("wr_addr", mem_addr, q_addr[0]);
                    chk("wr_data", mem_wdata, q_data[0]);
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                if (model_bad(in_op, $signed(in_imm))) begin
                    m_err = 1'b1;
                end else begin
                    q_addr.push_back(m_idx % CAP);
                    q_data.push_back(model_word(in_op, in_rd, in_rs1, in_rs2, $signed(in_imm)));
                    m_idx++;
                    m_issued++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_op  = op[2:0];
        in_rd  = rd[4:0];
        in_rs1 = rs1[4:0];
        in_rs2 = rs2[4:0];
        in_imm = imm;
    endtask

    task automatic rand_op(input bit allow_bad);
        int op;
        int imm;
        op = allow_bad ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
        case (op)
            2, 3, 4: imm = (allow_bad && $urandom_range(0, 7) == 0) ? int'($urandom)
                                                                      : int'($urandom_range(0, 4095)) - 2048;
            5:       imm = (allow_bad && $urandom_range(0, 7) == 0) ? int'($urandom)
                                                                      : (int'($urandom_range(0, 4095)) - 2048) * 2;
            default: imm = int'($urandom);
        endcase
        set_op(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), imm);
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
        bit acc = 1'b0;
        int n   = 0;
        set_op(op, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        mem_ready = 1'b1;
        while ((q_data.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, q_data.size(), 0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        chk("restart_len", prog_len, 0);
        chk("restart_ready", in_ready, 1);
        chk("restart_busy", busy, 0);
        chk("restart_err", err, 0);
        m_idx    = 0;
        m_issued = 0;
        m_err    = 1'b0;
        tick();
    endtask

    // ---------------- directed encodings ----------------
    int          d_op  [7] = '{0, 1, 2, 3, 4, 5, 6};
    int          d_rd  [7] = '{3, 3, 5, 6, 0, 0, 0};
    int          d_rs1 [7] = '{1, 1, 0, 1, 1, 1, 0};
    int          d_rs2 [7] = '{2, 2, 0, 0, 2, 2, 0};
    int          d_imm [7] = '{0, 0, -1, 8, 4, -4, 0};
    logic [31:0] d_exp [7] = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h0080A303,
                               32'h0020A223, 32'hFE208EE3, 32'h00000013};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc;
        int          guard;
        bit          have_snap;
        logic [40:0] snap;

        reset     = 1'b1;
        in_valid  = 1'b0;
        restart   = 1'b0;
        mem_ready = 1'b1;
        set_op(0, 0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        tick();

        // Directed words, one cycle accept-to-write latency each
        for (int i = 0; i < 7; i++) begin
            send(d_op[i], d_rd[i], d_rs1[i], d_rs2[i], d_imm[i]);
            @(negedge clk);
            chk("lat_we", mem_we, 1);
            chk("lat_word", mem_wdata, d_exp[i]);
            tick();
            @(negedge clk);
            chk("dir_prog_len", prog_len, i + 1);
            tick();
        end

        // Backpressure: memory stalled for 10 cycles while feeding
        mem_ready = 1'b0;
        acc       = 0;
        have_snap = 1'b0;
        snap      = '0;
        for (int c = 0; c < 10; c++) begin
            rand_op(1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            if (have_snap) begin
                chk("bp_hold", {mem_we, mem_addr, mem_wdata}, snap);
            end else if (mem_we) begin
                snap      = {mem_we, mem_addr, mem_wdata};
                have_snap = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepts", acc, DEPTH);
        chk("bp_in_ready", in_ready, 0);
        tick();
        wait_drain("bp_drain");
        chk("bp_prog_len", prog_len, m_idx);

        // Random stream until the address space is exhausted
        guard = 0;
        while (m_issued < CAP && guard < 5000) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            rand_op(1'b1);
            mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("fill_issued", m_issued, CAP);
        wait_drain("fill_drain");
        @(negedge clk);
        chk("done_prog_len", prog_len, CAP);
        chk("done_in_ready", in_ready, 0);
        chk("done_mem_we", mem_we, 0);
        chk("done_busy", busy, 0);
        chk("done_err", err, m_err);
        tick();

        // Further offers are refused once full
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            rand_op(1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("done_refused", acc, 0);

        // Restart rewinds to address 0
        do_restart();
        send(0, 7, 4, 5, 0);
        @(negedge clk);
        chk("rs_we", mem_we, 1);
        chk("rs_addr0", mem_addr, 0);
        chk("rs_word", mem_wdata, 32'h005203B3);
        tick();

`ifdef ENC_RANGE_CHECK_EN
        send(2, 5, 0, 0, 2048);
        @(negedge clk);
        chk("rc_err", err, 1);
        chk("rc_no_write", mem_we, 0);
        tick();
        send(0, 1, 2, 3, 0);
        @(negedge clk);
        chk("rc_next_we", mem_we, 1);
        chk("rc_next_addr", mem_addr, 1);
        tick();
`endif
        wait_drain("rs_drain");

        // Reset with words still queued discards them
        mem_ready = 1'b0;
        send(1, 9, 10, 11, 0);
        send(2, 12, 13, 0, 100);
        reset = 1'b1;
        q_data.delete();
        q_addr.delete();
        tick();
        reset    = 1'b0;
        m_idx    = 0;
        m_issued = 0;
        m_err    = 1'b0;
        @(negedge clk);
        chk("mr_mem_we", mem_we, 0);
        chk("mr_prog_len", prog_len, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        tick();

        // Short random stream after reset, then final accounting
        for (int c = 0; c < 60; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            rand_op(1'b1);
            mem_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            tick();
        end
        in_valid = 1'b0;
        wait_drain("final_drain");
        @(negedge clk);
        chk("final_prog_len", prog_len, m_idx);
        chk("final_err", err, m_err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
